// File: rtl/xillybus_ap_read_bridge_pkg.sv
// Shared types and defaults for the Xillybus <-> HLS ap_fifo bridges.
package xillybus_bridge_pkg;
  localparam int DATA_W_DEF     = 32;
  localparam int LEN_W_DEF      = 16;
  localparam int DEPTH_LOG2_DEF = 4;

  typedef enum logic [1:0] {CLOSED, STREAM, DRAIN, EOF} state_t;
endpackage

// File: rtl/xillybus_ap_read_bridge_if.sv
// ap_fifo sink side plus Xillybus read-stream side of the read bridge.
interface xillybus_ap_read_bridge_if
  import xillybus_bridge_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] out_r_din;
  logic              out_r_write;
  logic              out_r_full_n;
  logic              user_r_rden;
  logic              user_r_empty;
  logic [DATA_W-1:0] user_r_data;
  logic              user_r_eof;
  logic              user_r_open;

  modport slave (
    input  out_r_din, out_r_write, user_r_rden, user_r_open,
    output out_r_full_n, user_r_empty, user_r_data, user_r_eof
  );

  modport master (
    output out_r_din, out_r_write, user_r_rden, user_r_open,
    input  out_r_full_n, user_r_empty, user_r_data, user_r_eof
  );
endinterface

// File: rtl/xillybus_ap_read_bridge_fifo.sv
// Synchronous FIFO with registered read data and a synchronous flush.
module bridge_sync_fifo
  import xillybus_bridge_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_W-1:0]     din,
  input  logic                  pop,
  output logic [DATA_W-1:0]     dout,
  output logic [DEPTH_LOG2:0]   count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= din;

  // Flush wins over push/pop; dout keeps the last delivered word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        dout   <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/xillybus_ap_read_bridge.sv
// HLS ap_fifo output -> Xillybus FPGA-to-host stream, framed with EOF after frame_len words.
module xillybus_ap_read_bridge
  import xillybus_bridge_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic                 bus_clk,
  input  logic                 bus_rst_n,
  xillybus_ap_read_bridge_if.slave bus,
  input  logic [LEN_W-1:0]     frame_len,
  output logic [LEN_W-1:0]     words_sent,
  output logic                 overflow_err,
  output logic                 underflow_err
);
  localparam logic [DEPTH_LOG2:0] DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_ONE = 1;
  localparam logic [LEN_W-1:0]    LEN_ONE = 1;

  state_t              state, state_nxt;
  logic                open_q, open_rise;
  logic [LEN_W-1:0]    len_q, acc_cnt, acc_nxt;
  logic [DEPTH_LOG2:0] cnt;
  logic                full_n, empty, push, pop, flush;

  always_comb begin
    open_rise = bus.user_r_open && !open_q;
    full_n    = (state == STREAM) && (cnt < DEPTH);
    empty     = (state == CLOSED) || (state == EOF) || (cnt == '0);
    push      = bus.out_r_write && full_n;
    pop       = bus.user_r_rden && !empty;
    flush     = !bus.user_r_open;
    acc_nxt   = push ? acc_cnt + LEN_ONE : acc_cnt;
  end

  // Leaving STREAM on the accepting edge drops full_n right after the last word.
  always_comb begin
    state_nxt = state;
    if (!bus.user_r_open) state_nxt = CLOSED;
    else begin
      case (state)
        CLOSED: if (open_rise) state_nxt = STREAM;
        STREAM: if (len_q != '0 && acc_nxt == len_q) state_nxt = DRAIN;
        DRAIN:  if (cnt == '0 || (pop && cnt == CNT_ONE)) state_nxt = EOF;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state         <= CLOSED;
      open_q        <= 1'b0;
      len_q         <= '0;
      acc_cnt       <= '0;
      words_sent    <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      open_q <= bus.user_r_open;
      if (open_rise) begin
        len_q      <= frame_len;
        acc_cnt    <= '0;
        words_sent <= '0;
      end else begin
        acc_cnt <= acc_nxt;
        if (pop && words_sent != '1) words_sent <= words_sent + LEN_ONE;
      end
      if (bus.out_r_write && !full_n) overflow_err  <= 1'b1;
      if (bus.user_r_rden && empty)   underflow_err <= 1'b1;
    end
  end

  bridge_sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (bus_clk),
    .rst_n (bus_rst_n),
    .flush (flush),
    .push  (push),
    .din   (bus.out_r_din),
    .pop   (pop),
    .dout  (bus.user_r_data),
    .count (cnt)
  );

  assign bus.out_r_full_n = full_n;
  assign bus.user_r_empty = empty;
  assign bus.user_r_eof   = (state == EOF);
endmodule

// File: tb/tb_xillybus_ap_read_bridge.sv
// Directed + randomized bench for the read bridge against a queue-based frame model.
module tb_xillybus_ap_read_bridge;
  import xillybus_bridge_pkg::*;
  localparam int DW = 32, LW = 16, DEPTH = 16;

  logic          bus_clk = 1'b0, bus_rst_n = 1'b0;
  logic [LW-1:0] frame_len, words_sent;
  logic          overflow_err, underflow_err;

  xillybus_ap_read_bridge_if #(.DATA_W(DW)) bus ();

  xillybus_ap_read_bridge #(.DATA_W(DW), .DEPTH_LOG2(4), .LEN_W(LW)) dut (
    .bus_clk       (bus_clk),
    .bus_rst_n     (bus_rst_n),
    .bus           (bus),
    .frame_len     (frame_len),
    .words_sent    (words_sent),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 bus_clk = ~bus_clk;

  // Model: session open, frame complete, words accepted, words buffered, last delivered word.
  bit            m_sess, m_eof, m_ovf, m_udf, m_open_q;
  int            m_len, m_acc, m_sent;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data;
  int            checks = 0, errors = 0;

  function automatic bit exp_full_n();
    return m_sess && !m_eof && !(m_len != 0 && m_acc == m_len) && q.size() < DEPTH;
  endfunction

  function automatic bit exp_empty();
    return !m_sess || m_eof || q.size() == 0;
  endfunction

  task automatic mreset();
    m_sess = 0; m_eof = 0; m_ovf = 0; m_udf = 0; m_open_q = 0;
    m_len = 0; m_acc = 0; m_sent = 0; m_data = '0; q.delete();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".full_n"}, 64'(bus.out_r_full_n), 64'(exp_full_n()));
    chk({tag, ".empty"},  64'(bus.user_r_empty), 64'(exp_empty()));
    chk({tag, ".eof"},    64'(bus.user_r_eof),   64'(m_eof));
    chk({tag, ".data"},   64'(bus.user_r_data),  64'(m_data));
    chk({tag, ".sent"},   64'(words_sent),       64'(m_sent));
    chk({tag, ".ovf"},    64'(overflow_err),     64'(m_ovf));
    chk({tag, ".udf"},    64'(underflow_err),    64'(m_udf));
  endtask

  // Advance one clock with the inputs currently driven, then compare everything.
  task automatic step(input string tag);
    bit wr_ok, rd_ok, open, rise;
    logic [DW-1:0] d;
    wr_ok = bus.out_r_write && exp_full_n();
    rd_ok = bus.user_r_rden && !exp_empty();
    if (bus.out_r_write && !exp_full_n()) m_ovf = 1;
    if (bus.user_r_rden && exp_empty())   m_udf = 1;
    open = bus.user_r_open;
    rise = open && !m_open_q;
    d    = bus.out_r_din;
    @(posedge bus_clk);
    if (rd_ok) begin
      if (m_sent < 65535) m_sent++;
      if (open) m_data = q.pop_front();
    end
    if (wr_ok) begin
      m_acc++;
      if (open) q.push_back(d);
    end
    if (!open) begin
      m_sess = 0; m_eof = 0; q.delete();
    end else if (rise) begin
      m_sess = 1; m_len = int'(frame_len); m_acc = 0; m_sent = 0;
    end else if (m_sess && m_len != 0 && m_acc == m_len && q.size() == 0) m_eof = 1;
    m_open_q = open;
    #1;
    check_all(tag);
  endtask

  // Well-behaved producer/consumer: only act when the model says the handshake allows it.
  task automatic drive(input bit wr, input bit rd, input logic [DW-1:0] d);
    bus.out_r_write = wr && exp_full_n();
    bus.out_r_din   = d;
    bus.user_r_rden = rd && !exp_empty();
  endtask

  task automatic idle();
    bus.out_r_write = 0;
    bus.user_r_rden = 0;
  endtask

  initial begin
    bus.out_r_din = '0; bus.out_r_write = 0; bus.user_r_rden = 0; bus.user_r_open = 0;
    frame_len = '0;
    mreset();
    #3 check_all("reset");
    #4 bus_rst_n = 1'b1;

    // Frame of 4, back-to-back writes, continuous reads.
    frame_len = 16'd4; bus.user_r_open = 1; idle();
    step("p1_open");
    for (int i = 0; i < 30 && !m_eof; i++) begin
      drive(m_acc < 4, 1, 32'hA0 + 32'(m_acc));
      step("p1");
    end
    chk("p1_eof", 64'(bus.user_r_eof), 64'd1);
    chk("p1_sent", 64'(words_sent), 64'd4);
    chk("p1_last", 64'(bus.user_r_data), 64'hA3);

    // Endless stream of 40 words, host stalls while the buffer fills.
    bus.user_r_open = 0; idle(); step("p2_close");
    frame_len = 16'd0; bus.user_r_open = 1; step("p2_open");
    for (int i = 0; i < 20; i++) begin
      drive(m_acc < 40, 0, $urandom);
      step("p2_stall");
    end
    chk("p2_full", 64'(bus.out_r_full_n), 64'd0);
    for (int i = 0; i < 400 && m_sent < 40; i++) begin
      drive(m_acc < 40 && $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom);
      step("p2");
    end
    chk("p2_sent", 64'(words_sent), 64'd40);
    chk("p2_noeof", 64'(bus.user_r_eof), 64'd0);

    // One word buffered, push and pop in the same cycle.
    drive(1, 0, 32'hB000_0000); step("p3_a");
    drive(1, 1, 32'hB000_0001); step("p3_ab");
    chk("p3_dataA", 64'(bus.user_r_data), 64'hB000_0000);
    chk("p3_empty", 64'(bus.user_r_empty), 64'd0);
    drive(0, 1, '0); step("p3_b");
    chk("p3_dataB", 64'(bus.user_r_data), 64'hB000_0001);

    // Close after 2 of 8 words, reopen with a 3-word frame.
    bus.user_r_open = 0; idle(); step("p4_close0");
    frame_len = 16'd8; bus.user_r_open = 1; step("p4_open");
    drive(1, 0, 32'hC0); step("p4_w0");
    drive(1, 0, 32'hC1); step("p4_w1");
    idle(); bus.user_r_open = 0; step("p4_close");
    chk("p4_empty", 64'(bus.user_r_empty), 64'd1);
    chk("p4_fulln", 64'(bus.out_r_full_n), 64'd0);
    frame_len = 16'd3; bus.user_r_open = 1; step("p4_reopen");
    chk("p4_sent0", 64'(words_sent), 64'd0);
    for (int i = 0; i < 100 && !m_eof; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 32'hD0 + 32'(m_acc));
      step("p4");
    end
    chk("p4_eof", 64'(bus.user_r_eof), 64'd1);
    chk("p4_sent", 64'(words_sent), 64'd3);

    // Protocol violations while closed; flags must survive a reopen.
    bus.user_r_open = 0; idle(); step("p5_close");
    bus.out_r_write = 1; bus.user_r_rden = 1; bus.out_r_din = 32'hDEAD; step("p5_viol");
    chk("p5_ovf", 64'(overflow_err), 64'd1);
    chk("p5_udf", 64'(underflow_err), 64'd1);
    idle(); frame_len = 16'd2; bus.user_r_open = 1; step("p5_reopen");
    for (int i = 0; i < 40 && !m_eof; i++) begin
      drive(1, 1, 32'hE0 + 32'(m_acc));
      step("p5");
    end
    chk("p5_eof", 64'(bus.user_r_eof), 64'd1);
    chk("p5_ovf_keep", 64'(overflow_err), 64'd1);

    // Randomized sessions, including mid-frame closes and stray violations.
    for (int s = 0; s < 8; s++) begin
      bus.user_r_open = 0; idle(); step("rnd_close");
      frame_len = 16'($urandom_range(0, 24)); bus.user_r_open = 1; step("rnd_open");
      for (int i = 0; i < 150; i++) begin
        drive($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom);
        if ($urandom_range(0, 60) == 0) bus.user_r_rden = 1;
        if ($urandom_range(0, 60) == 0) bus.out_r_write = 1;
        step("rnd");
      end
    end

    // Async reset in the middle of a frame.
    bus.user_r_open = 0; idle(); step("p7_close");
    frame_len = 16'd10; bus.user_r_open = 1; step("p7_open");
    for (int i = 0; i < 5; i++) begin
      drive(1, i > 2, $urandom);
      step("p7");
    end
    #2 bus_rst_n = 1'b0;
    mreset();
    #1 check_all("p7_async_rst");
    chk("p7_fulln", 64'(bus.out_r_full_n), 64'd0);
    chk("p7_empty", 64'(bus.user_r_empty), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
